instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  PC generator and fetch buffer directly upstream of the instruction ROM.
//  Holds the 64-bit byte PC and drives the ROM word address each cycle.
//  Captures the ROM's combinational instruction with its PC into a small FIFO.
//  Hands {pc, instr} to decode over a valid/ready handshake.
//  Accepts branch/jump redirects from execute.
// PARAMETERS
//  ADDR_WIDTH   8             ROM word-address width (256 words)
//  INST_WIDTH   32            instruction width
//  PC_WIDTH     64            PC width
//  FQ_DEPTH     2             fetch-queue entries (power of 2, >=2)
//  RESET_PC     64'h0         PC loaded on reset
// PORTS
//  i_clk          in   1           clock, rising edge
//  i_rst          in   1           synchronous reset, active high
//  o_imem_addr    out  ADDR_WIDTH  ROM word address = pc[ADDR_WIDTH+1:2]
//  i_imem_instr   in   INST_WIDTH  ROM data, combinational from o_imem_addr
//  i_redirect     in   1           take new PC this cycle
//  i_redirect_pc  in   PC_WIDTH    redirect target (byte address)
//  o_valid        out  1           head entry valid toward decode
//  i_ready        in   1           decode accepts head entry
//  o_pc           out  PC_WIDTH    PC of head entry
//  o_instr        out  INST_WIDTH  instruction of head entry
//  o_fetch_fault  out  1           misaligned-redirect fault (see CONFIGURATION)
//  o_fault_pc     out  PC_WIDTH    offending redirect target
// BEHAVIOUR
//  - Reset (sync, i_rst=1 at edge):
//    - pc=RESET_PC, queue count=0, o_valid=0.
//    - o_fetch_fault=0, o_fault_pc=0.
//  - Output rules:
//    - o_pc/o_instr are 0 when o_valid=0.
//    - o_valid = (count!=0).
//  - Handshake:
//    - Pop when o_valid&i_ready.
//    - Head must stay stable while o_valid&!i_ready.
//  - Fetch condition: fetch = !i_redirect & !fault & (count<FQ_DEPTH | pop).
//    - On fetch: push {pc, i_imem_instr}; pc <= pc+4.
//    - Simultaneous push+pop at full is legal; count unchanged.
//  - Latency and throughput:
//    - Instruction reaches o_instr 1 cycle after its PC is driven.
//    - Sustains 1 instr/cycle with i_ready held high.
//  - Redirect: i_redirect=1 has priority over fetch.
//    - Queue flushed (count=0 next cycle).
//    - pc <= i_redirect_pc; no push that cycle.
//    - A pop coinciding with redirect counts as completed.
//    - o_valid=0 in the following cycle.
//    - First target instr is valid 2 cycles after the redirect edge.
//  - Wrap-around:
//    - pc+4 wraps modulo 2^PC_WIDTH.
//    - o_imem_addr wraps modulo 2^ADDR_WIDTH (pc 0x3FC -> 0x400 gives addr 0xFF -> 0x00).
//  - Reset mid-operation: all queued entries discarded; no partial state survives.
//  - Empty queue with i_ready=1: no pop; count never underflows.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined:
//    - A redirect with i_redirect_pc[1:0]!=0 sets o_fetch_fault=1.
//    - The same redirect sets o_fault_pc=i_redirect_pc and halts fetch.
//    - Queue is flushed; o_valid stays 0.
//    - The fault clears only on reset or on a later aligned redirect, which resumes fetch.
//  Not defined:
//    - pc[1:0] forced to 2'b00 on redirect.
//    - o_fetch_fault and o_fault_pc tied 0.
// STRUCTURE
//  Package fetch_pkg:
//    - fetch_entry_t struct {pc, instr}.
//    - INST_BYTES=4, default RESET_PC, default FQ_DEPTH.
//  Sub-module fetch_queue:
//    - Sync FIFO of fetch_entry_t: push, pop, flush, count, head.
//    - flush has priority over push.
//    - Remaining PC/redirect/fault logic lives in this module.
// TESTING
//  1. Reset, ROM words 0..3 = 0x11,0x22,0x33,0x44, i_ready=1
//     -> (pc,instr) = (0,0x11),(4,0x22),(8,0x33),(C,0x44) on consecutive cycles.
//  2. i_ready=0 for 5 cycles
//     -> count saturates at FQ_DEPTH, pc frozen at 8, head (0,0x11) stable.
//     -> Release: in-order drain, no loss or duplication.
//  3. Redirect to 0x40 while queue full
//     -> next cycle o_valid=0.
//     -> Following cycle (0x40, ROM[16]); stale entries never appear.
//  4. Redirect coinciding with pop: popped entry counted once, others dropped.
//     Then pc=0x3FC fetches ROM[0xFF], then ROM[0x00] at pc 0x400.
//  5. Reset asserted with 2 entries queued -> next cycle o_valid=0, o_pc=0, pc=RESET_PC.
//  6. FETCH_MISALIGN_CHECK_EN: redirect to 0x42
//     -> o_fetch_fault=1, o_fault_pc=0x42, no fetch.
//     -> Redirect to 0x80 clears the fault and resumes at 0x80.
//     Without the macro: 0x42 fetches from 0x40.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t : one fetch-queue record {pc, instr}
//   INST_BYTES    : byte stride between consecutive instructions
//   DEFAULT_*     : default PC / queue geometry used by the top's parameters
//   word_align()  : clears the byte-offset bits of a PC
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_W               = 64;
    localparam int INST_W             = 32;
    localparam int INST_BYTES         = 4;
    localparam int DEFAULT_FQ_DEPTH   = 2;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 64'h0;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles every non-clock/reset signal of the fetch unit.
//   ROM side     : o_imem_addr (word address out), i_imem_instr (combinational data in)
//   Execute side : i_redirect, i_redirect_pc
//   Decode side  : o_valid, i_ready, o_pc, o_instr
//   Fault report : o_fetch_fault, o_fault_pc
// Modports:
//   master : the fetch unit itself
//   slave  : its surroundings (ROM, execute, decode)
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = fetch_pkg::INST_W,
    parameter int PC_WIDTH   = fetch_pkg::PC_W
) ();

    logic [ADDR_WIDTH-1:0] o_imem_addr;
    logic [INST_WIDTH-1:0] i_imem_instr;
    logic                  i_redirect;
    logic [PC_WIDTH-1:0]   i_redirect_pc;
    logic                  o_valid;
    logic                  i_ready;
    logic [PC_WIDTH-1:0]   o_pc;
    logic [INST_WIDTH-1:0] o_instr;
    logic                  o_fetch_fault;
    logic [PC_WIDTH-1:0]   o_fault_pc;

    modport master (
        output o_imem_addr,
        input  i_imem_instr,
        input  i_redirect,
        input  i_redirect_pc,
        output o_valid,
        input  i_ready,
        output o_pc,
        output o_instr,
        output o_fetch_fault,
        output o_fault_pc
    );

    modport slave (
        input  o_imem_addr,
        output i_imem_instr,
        output i_redirect,
        output i_redirect_pc,
        input  o_valid,
        output i_ready,
        input  o_pc,
        input  o_instr,
        input  o_fetch_fault,
        input  o_fault_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO of fetch_entry_t with show-ahead head output.
//   clk, srst  : clock, synchronous active-high reset
//   push       : write push_entry at the tail
//   pop        : retire the head entry
//   flush      : empty the queue; wins over push
//   push_entry : entry to write
//   head       : current head entry (meaningful only when count != 0)
//   count      : number of entries held (0..DEPTH)
// DEPTH must be a power of two and >= 2 so the pointers wrap for free.
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FQ_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok, pop_ok;

    // Guard against underflow/overflow even if the caller misbehaves;
    // a push into a full queue is accepted only alongside a pop.
    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && !flush && ((count_reg < DEPTH_C) || pop_ok);

    // Storage is not reset: pointers and count define validity.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_entry;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// PC generator plus fetch queue sitting directly in front of the instruction ROM.
// Each cycle the current PC addresses the ROM; the combinational ROM word is
// captured with its PC into fetch_queue and presented to decode over
// valid/ready. Execute can redirect the PC at any time; a redirect flushes
// the queue and takes priority over fetching.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (master) : ROM address/data, redirect, decode handshake, fault report
// Optional feature (macro FETCH_MISALIGN_CHECK_EN):
//   defined   - a redirect to a non-word-aligned target raises o_fetch_fault,
//               records o_fault_pc and halts fetch until reset or an aligned
//               redirect.
//   undefined - redirect targets are word-aligned by dropping pc[1:0];
//               o_fetch_fault / o_fault_pc stay 0.
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = INST_W,
    parameter int PC_WIDTH   = PC_W,
    parameter int FQ_DEPTH   = DEFAULT_FQ_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    instruction_fetch_unit_if.master  bus
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic                fault_reg, fault_next;
    logic [PC_WIDTH-1:0] fault_pc_reg, fault_pc_next;

    logic [CW-1:0] count;
    fetch_entry_t  head, push_entry;
    logic          valid, pop, fetch;

    assign valid = (count != '0);
    assign pop   = valid && bus.i_ready;
    // A full queue can still accept this cycle's fetch if decode frees a slot.
    assign fetch = !bus.i_redirect && !fault_reg && ((count < DEPTH_C) || pop);

    assign push_entry.pc    = pc_reg;
    assign push_entry.instr = bus.i_imem_instr;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (i_clk),
        .srst       (i_rst),
        .push       (fetch),
        .pop        (pop),
        .flush      (bus.i_redirect),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    always_comb begin
        pc_next       = pc_reg;
        fault_next    = fault_reg;
        fault_pc_next = fault_pc_reg;
        if (bus.i_redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            pc_next = bus.i_redirect_pc;
            if (bus.i_redirect_pc[1:0] != 2'b00) begin
                fault_next    = 1'b1;
                fault_pc_next = bus.i_redirect_pc;
            end else begin
                fault_next    = 1'b0;
                fault_pc_next = '0;
            end
`else
            pc_next = word_align(bus.i_redirect_pc);
`endif
        end else if (fetch) begin
            // Natural modulo-2^PC_WIDTH wrap.
            pc_next = pc_reg + PC_WIDTH'(INST_BYTES);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_reg       <= RESET_PC;
            fault_reg    <= 1'b0;
            fault_pc_reg <= '0;
        end else begin
            pc_reg       <= pc_next;
            fault_reg    <= fault_next;
            fault_pc_reg <= fault_pc_next;
        end
    end

    // Word address simply truncates, so it wraps modulo 2^ADDR_WIDTH.
    assign bus.o_imem_addr   = pc_reg[ADDR_WIDTH+1:2];
    assign bus.o_valid       = valid;
    assign bus.o_pc          = valid ? head.pc    : '0;
    assign bus.o_instr       = valid ? head.instr : '0;
    assign bus.o_fetch_fault = fault_reg;
    assign bus.o_fault_pc    = fault_pc_reg;

endmodule
